gb_interrupt_ctrl: RTL and testbench

//  Receiving end of the peripheral interrupt lines (timer overflow, VBlank, STAT, serial, joypad).

---
 rtl/gb_int_pkg.sv | 26 ++
 rtl/gb_irq_prio_enc.sv | 27 ++
 rtl/gb_interrupt_ctrl.sv | 122 ++++++++++++
 tb/tb_gb_interrupt_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gb_int_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gb_int_pkg                                                           |
// | Shared constants and state type for the Game Boy interrupt block.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gb_int_pkg;

    localparam logic [15:0] IF_ADDR     = 16'hFF0F;
    localparam logic [15:0] IE_ADDR     = 16'hFFFF;
    localparam logic [7:0]  VECTOR_BASE = 8'h40;

    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;
    localparam int NUM_INT    = INT_JOYPAD + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } int_state_t;

endpackage : gb_int_pkg
`default_nettype wire

// File: rtl/gb_irq_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gb_irq_prio_enc                                                      |
// | Fixed-priority encoder; the lowest set index wins.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gb_irq_prio_enc
    import gb_int_pkg::*;
(
    input  logic [NUM_INT-1:0] vec,
    output logic               any,
    output logic [2:0]         idx
);

    always_comb begin
        any = |vec;
        idx = 3'd0;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule : gb_irq_prio_enc
`default_nettype wire

// File: rtl/gb_interrupt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gb_interrupt_ctrl                                                    |
// | IF/IE registers, bus access, priority arbitration, dispatch handshake|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gb_interrupt_ctrl #(
    parameter logic [15:0] IF_ADDR     = gb_int_pkg::IF_ADDR,
    parameter logic [15:0] IE_ADDR     = gb_int_pkg::IE_ADDR,
    parameter logic [7:0]  VECTOR_BASE = gb_int_pkg::VECTOR_BASE
) (
    input  logic        clockgb,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    input  logic [4:0]  src_req,
    output logic        irq,
    output logic        wake,
    input  logic        int_ack,
    output logic        vector_valid,
    output logic [7:0]  int_vector
);

    import gb_int_pkg::*;

    logic [NUM_INT-1:0] r_if;
    logic [7:0]         r_ie;
    logic [7:0]         r_outdata;
    logic [7:0]         r_vector;
    int_state_t         r_state;
    int_state_t         w_state_next;

    logic               w_if_hit;
    logic               w_ie_hit;
    logic [NUM_INT-1:0] w_pending;
    logic               w_any;
    logic [2:0]         w_idx;
    logic               w_dispatch;
    logic [NUM_INT-1:0] w_ack_clear;
    logic [NUM_INT-1:0] w_if_next;
    logic [7:0]         w_rd_data;

    assign w_if_hit  = (address == IF_ADDR);
    assign w_ie_hit  = (address == IE_ADDR);
    assign w_pending = r_if & r_ie[NUM_INT-1:0];

    gb_irq_prio_enc u_prio_enc (
        .vec (w_pending),
        .any (w_any),
        .idx (w_idx)
    );

    always_comb begin
        w_state_next = r_state;
        w_dispatch   = 1'b0;
        case (r_state)
            IDLE: begin
                if (int_ack) begin
                    w_dispatch   = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (!int_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A late source request must survive both the ack clear and a bus write.
    assign w_ack_clear = (w_dispatch && w_any) ? (NUM_INT'(1) << w_idx) : '0;
    assign w_if_next   = src_req
                       | ((store && w_if_hit) ? indata[NUM_INT-1:0] : r_if) & ~w_ack_clear;

    always_comb begin
        w_rd_data = 8'h00;
        if (w_if_hit) begin
            w_rd_data = {3'b111, r_if};
        end else if (w_ie_hit) begin
            w_rd_data = r_ie;
        end
    end

    always_ff @(posedge clockgb) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clockgb) begin
        if (reset) begin
            r_if      <= '0;
            r_ie      <= 8'h00;
            r_outdata <= 8'h00;
            r_vector  <= 8'h00;
        end else begin
            r_if      <= w_if_next;
            r_outdata <= load ? w_rd_data : 8'h00;
            if (store && w_ie_hit) begin
                r_ie <= indata;
            end
            if (w_dispatch) begin
                r_vector <= w_any ? (VECTOR_BASE + {2'b00, w_idx, 3'b000}) : 8'h00;
            end
        end
    end

    assign irq          = |w_pending;
    assign wake         = |w_pending;
    assign outdata      = r_outdata;
    assign vector_valid = (r_state == HOLD);
    assign int_vector   = r_vector;

endmodule : gb_interrupt_ctrl
`default_nettype wire

// File: tb/tb_gb_interrupt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gb_interrupt_ctrl                                                 |
// | Directed scoreboard bench for gb_interrupt_ctrl.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gb_interrupt_ctrl;

    import gb_int_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic [7:0]  indata;
    logic [7:0]  outdata;
    logic        load;
    logic        store;
    logic [4:0]  src_req;
    logic        irq;
    logic        wake;
    logic        int_ack;
    logic        vector_valid;
    logic [7:0]  int_vector;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    gb_interrupt_ctrl u_dut (
        .clockgb      (clk),
        .reset        (rst),
        .address      (address),
        .indata       (indata),
        .outdata      (outdata),
        .load         (load),
        .store        (store),
        .src_req      (src_req),
        .irq          (irq),
        .wake         (wake),
        .int_ack      (int_ack),
        .vector_valid (vector_valid),
        .int_vector   (int_vector)
    );

    task automatic push(input logic [7:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        store = 1'b1; address = a; indata = d;
        @(negedge clk);
        store = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string tag);
        @(negedge clk);
        load = 1'b1; address = a;
        push(e);
        @(negedge clk);
        load = 1'b0;
        check(tag, outdata);
    endtask

    task automatic pulse(input logic [4:0] s);
        @(negedge clk);
        src_req = s;
        @(negedge clk);
        src_req = 5'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; address = 16'h0000; indata = 8'h00; load = 1'b0;
        store = 1'b0; src_req = 5'h00; int_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        push(8'h00); check("reset_outdata", outdata);
        push(8'h00); check("reset_valid", {7'd0, vector_valid});
        push(8'h00); check("reset_vector", int_vector);
        push(8'h00); check("reset_irq", {7'd0, irq});

        // Test 1: single timer request
        bus_write(IE_ADDR, 8'h04);
        @(negedge clk);
        src_req = 5'(1 << INT_TIMER);
        push(8'h01);
        @(negedge clk);
        src_req = 5'h00;
        check("t1_irq_next_cycle", {7'd0, irq});
        push(8'h01); check("t1_wake", {7'd0, wake});
        bus_read(IF_ADDR, 8'hE4, "t1_if_read");

        // Test 2: simultaneous VBlank + joypad, priority and re-ack
        bus_write(IF_ADDR, 8'h00);
        bus_write(IE_ADDR, 8'h1F);
        pulse(5'(1 << INT_JOYPAD) | 5'(1 << INT_VBLANK));
        @(negedge clk);
        int_ack = 1'b1;
        push(8'h00); check("t2_valid_latency0", {7'd0, vector_valid});
        push(8'h01); push(8'h40);
        @(negedge clk);
        check("t2_valid", {7'd0, vector_valid});
        check("t2_vector_vblank", int_vector);
        bus_read(IF_ADDR, 8'hF0, "t2_if_after_ack");
        push(8'h40); check("t2_vector_frozen", int_vector);
        int_ack = 1'b0;
        push(8'h00);
        @(negedge clk);
        check("t2_valid_drop", {7'd0, vector_valid});
        int_ack = 1'b1;
        push(8'h60);
        @(negedge clk);
        check("t2_vector_joypad", int_vector);
        int_ack = 1'b0;
        @(negedge clk);

        // Test 3: IE write racing the ack
        bus_write(IE_ADDR, 8'h04);
        pulse(5'(1 << INT_TIMER));
        @(negedge clk);
        int_ack = 1'b1; store = 1'b1; address = IE_ADDR; indata = 8'h00;
        push(8'h50);
        @(negedge clk);
        store = 1'b0;
        check("t3_same_cycle_old_ie", int_vector);
        int_ack = 1'b0;
        @(negedge clk);
        bus_write(IE_ADDR, 8'h04);
        pulse(5'(1 << INT_TIMER));
        bus_write(IE_ADDR, 8'h00);
        int_ack = 1'b1;
        push(8'h01); push(8'h00);
        @(negedge clk);
        check("t3_early_valid", {7'd0, vector_valid});
        check("t3_early_vector_none", int_vector);
        bus_read(IF_ADDR, 8'hE4, "t3_if_not_cleared");
        int_ack = 1'b0;
        @(negedge clk);

        // Test 4: source beats bus write
        @(negedge clk);
        src_req = 5'(1 << INT_STAT); store = 1'b1; address = IF_ADDR; indata = 8'h00;
        @(negedge clk);
        src_req = 5'h00; store = 1'b0;
        bus_read(IF_ADDR, 8'hE2, "t4_source_wins");

        // Test 5: unmapped read, full IE readback, IE[7:5] ignored for irq
        bus_read(16'hFF05, 8'h00, "t5_unmapped");
        bus_write(IE_ADDR, 8'hFF);
        bus_read(IE_ADDR, 8'hFF, "t5_ie_read");
        push(8'h01); check("t5_irq_bit1", {7'd0, irq});
        bus_write(IF_ADDR, 8'h1F);
        bus_write(IE_ADDR, 8'hE0);
        push(8'h00); check("t5_irq_high_ie_only", {7'd0, irq});
        push(8'h00); check("t5_wake_high_ie_only", {7'd0, wake});

        // Test 6: reset during HOLD
        bus_write(IF_ADDR, 8'h00);
        bus_write(IE_ADDR, 8'h01);
        pulse(5'(1 << INT_VBLANK));
        @(negedge clk);
        int_ack = 1'b1;
        push(8'h01);
        @(negedge clk);
        check("t6_in_hold", {7'd0, vector_valid});
        rst = 1'b1;
        push(8'h00); push(8'h00); push(8'h00);
        @(negedge clk);
        rst = 1'b0; int_ack = 1'b0;
        check("t6_valid_after_reset", {7'd0, vector_valid});
        check("t6_vector_after_reset", int_vector);
        check("t6_irq_after_reset", {7'd0, irq});
        bus_read(IF_ADDR, 8'hE0, "t6_if_after_reset");
        bus_read(IE_ADDR, 8'h00, "t6_ie_after_reset");

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gb_interrupt_ctrl
`default_nettype wire
